// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues one-word reads to the
// instruction cache and queues returned words with their PC for decode.
module cpu_ifetch #(
  parameter logic [31:0] RESET_ADDR = 32'hFFFF0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        cpui_request,
  output logic [31:0] cpui_addr,
  input  logic [31:0] cpui_rdata,
  input  logic        cpui_ack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [31:0] jump_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     fetch_pc, req_pc;
  logic            outstanding, discard;

  logic [31:0]     target;
  logic            if_free, credit_ok, issue, push, pop;
  logic [CW:0]     in_use;
  logic            unused_addr_bits;

  assign target           = {jump_addr[31:2], 2'b00};
  assign unused_addr_bits = ^jump_addr[1:0];

  // The ack cycle frees the interface, so a new request can follow back-to-back.
  assign if_free   = !outstanding || cpui_ack;
  // A live in-flight word already owns a FIFO slot; a discarded one does not.
  assign in_use    = {1'b0, count} + {{CW{1'b0}}, (outstanding && !discard)};
  assign credit_ok = in_use < (CW+1)'(FIFO_DEPTH);

  // A redirect flushes the FIFO, so it only needs a free interface to issue.
  assign issue        = !reset && if_free && (jump || credit_ok);
  assign cpui_request = issue;
  assign cpui_addr    = jump ? target : fetch_pc;

  assign push = cpui_ack && outstanding && !discard && !jump;
  assign pop  = instr_valid && instr_ready && !jump;

  assign instr_valid = (count != '0);
  assign instr       = mem[rd_ptr].word;
  assign instr_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_ADDR;
      req_pc      <= RESET_ADDR;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= cpui_addr;
      end else if (cpui_ack) begin
        outstanding <= 1'b0;
      end

      // A redirect with an unacked request in flight marks that response stale.
      if (jump && outstanding && !cpui_ack)
        discard <= 1'b1;
      else if (cpui_ack)
        discard <= 1'b0;

      if (jump)
        fetch_pc <= issue ? target + 32'd4 : target;
      else if (issue)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (jump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push)
      mem[wr_ptr] <= '{pc: req_pc, word: cpui_rdata};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && cpui_ack && !outstanding)
      $warning("cpu_ifetch: cache ack with no request outstanding");
  end
`endif

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch: a latency-programmable cache model plus a stream-level
// reference of expected request addresses, decode PCs and FIFO occupancy.
module tb_cpu_ifetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST   = 32'hFFFF0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpui_request;
  logic [31:0] cpui_addr;
  logic [31:0] cpui_rdata = '0;
  logic        cpui_ack = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;

  cpu_ifetch #(.RESET_ADDR(RST), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpui_request(cpui_request), .cpui_addr(cpui_addr),
    .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0, rst_cycles = 0;
  // cache model: at most one pending request
  logic        pend_v = 1'b0, live = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_lat = 0, lat = 1;
  logic [31:0] poison = 32'h1;
  bit          stale_seen = 0;
  // stream reference
  logic [31:0] exp_req = RST, exp_pop = RST;
  int          mdl_cnt = 0;
  logic [31:0] req_a[$], pop_p[$];
  int          req_c[$], pop_c[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge; inputs set by the
  // caller are already stable, outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] tgt;
    cpui_ack   = 1'b0;
    cpui_rdata = '0;
    if (pend_v && pend_lat == 0) begin
      cpui_ack   = 1'b1;
      cpui_rdata = (pend_addr == poison) ? 32'hDEADBEEF : memf(pend_addr);
    end
    #1;
    tgt = {jump_addr[31:2], 2'b00};
    if (reset) begin
      chk("rst_request", cpui_request, 1'b0);
      if (rst_cycles > 0) chk("rst_instr_valid", instr_valid, 1'b0);
      rst_cycles++;
      if (cpui_ack) begin
        stale_seen = 1;
        pend_v = 1'b0;
      end else if (pend_v) pend_lat--;
      live = 1'b0; mdl_cnt = 0; exp_req = RST; exp_pop = RST;
    end else begin
      rst_cycles = 0;
      chk("valid_vs_model", instr_valid, (mdl_cnt != 0));
      if (instr_valid && instr_ready && !jump) begin
        chk("pop_pc", instr_pc, exp_pop);
        chk("pop_data", instr, memf(instr_pc));
        pop_p.push_back(instr_pc); pop_c.push_back(cyc);
        exp_pop = exp_pop + 32'd4;
        mdl_cnt--;
      end
      if (cpui_ack) begin
        if (live && !jump) mdl_cnt++;
        pend_v = 1'b0;
      end else if (pend_v) pend_lat--;
      if (jump) begin
        mdl_cnt = 0;
        exp_pop = tgt;
        if (pend_v) live = 1'b0;
      end
      if (cpui_request) begin
        chk("no_overlap", (pend_v && !cpui_ack), 1'b0);
        chk("req_addr", cpui_addr, jump ? tgt : exp_req);
        req_a.push_back(cpui_addr); req_c.push_back(cyc);
        exp_req   = cpui_addr + 32'd4;
        pend_v    = 1'b1;
        pend_addr = cpui_addr;
        pend_lat  = lat - 1;
        live      = 1'b1;
      end else if (jump) begin
        exp_req = tgt;
      end
      chk("credit", ((mdl_cnt + ((pend_v && live) ? 1 : 0)) <= DEPTH), 1'b1);
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    jump  = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < 20 && pend_v; g++) tick();
    reset = 1'b0;
    poison = 32'h1;
    req_a.delete(); req_c.delete(); pop_p.delete(); pop_c.delete();
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);

    // sequential fetch with 1-cycle acks
    do_reset(); lat = 1; instr_ready = 1'b1;
    repeat (8) tick();
    chk("t1_req0", req_a[0], 32'hFFFF0000);
    chk("t1_req1", req_a[1], 32'hFFFF0004);
    chk("t1_req2", req_a[2], 32'hFFFF0008);
    chk("t1_req2_cycle", req_c[2], 2);
    chk("t1_pop_latency", pop_c[0], req_c[0] + 2);
    chk("t1_pop1", pop_p[1], 32'hFFFF0004);
    chk("t1_pop2", pop_p[2], 32'hFFFF0008);

    // FIFO fills, issue stops at four, one pop buys exactly one more
    do_reset(); instr_ready = 1'b0;
    repeat (8) tick();
    chk("t2_req_count_full", req_a.size(), 4);
    chk("t2_valid_full", instr_valid, 1'b1);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    repeat (3) tick();
    chk("t2_req_count_after_pop", req_a.size(), 5);
    chk("t2_req4_addr", req_a[4], 32'hFFFF0010);
    chk("t2_req4_cycle", req_c[4], pop_c[0] + 1);

    // jump while a slow request is in flight: its word must be dropped
    do_reset(); instr_ready = 1'b1; lat = 1; poison = 32'hFFFF0008;
    tick(); tick();
    lat = 6; tick(); lat = 1;
    tick();
    jump = 1'b1; jump_addr = 32'h00001002; tick(); jump = 1'b0;
    repeat (8) tick();
    chk("t3_req_after_jump", req_a[3], 32'h00001000);
    chk("t3_req_at_ack_cycle", req_c[3], 8);
    chk("t3_pop_after_jump", pop_p[2], 32'h00001000);

    // jump in the same cycle as an ack
    do_reset(); instr_ready = 1'b0; lat = 1;
    tick(); tick();
    jump = 1'b1; jump_addr = 32'h00002000; tick(); jump = 1'b0;
    chk("t4_fifo_flushed", instr_valid, 1'b0);
    chk("t4_jump_req_addr", req_a[2], 32'h00002000);
    chk("t4_jump_req_cycle", req_c[2], 2);
    instr_ready = 1'b1;
    repeat (4) tick();
    chk("t4_first_pop", pop_p[0], 32'h00002000);

    // address wrap
    do_reset(); instr_ready = 1'b1; lat = 1;
    jump = 1'b1; jump_addr = 32'hFFFFFFFC; tick(); jump = 1'b0;
    repeat (6) tick();
    chk("t5_req0", req_a[0], 32'hFFFFFFFC);
    chk("t5_req1", req_a[1], 32'h00000000);
    chk("t5_req2", req_a[2], 32'h00000004);
    chk("t5_pop0", pop_p[0], 32'hFFFFFFFC);
    chk("t5_pop1", pop_p[1], 32'h00000000);
    chk("t5_pop2", pop_p[2], 32'h00000004);

    // reset with a request in flight; its ack lands during reset
    do_reset(); instr_ready = 1'b1; lat = 4;
    repeat (2) tick();
    stale_seen = 0;
    do_reset(); lat = 1;
    chk("t6_stale_ack_in_reset", stale_seen, 1'b1);
    repeat (6) tick();
    chk("t6_first_req", req_a[0], RST);
    chk("t6_first_pop", pop_p[0], RST);

    // randomized traffic against the stream reference
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      lat         = $urandom_range(1, 4);
      jump        = ($urandom_range(0, 19) == 0);
      jump_addr   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom;
      tick();
    end
    jump = 1'b0;
    chk("rand_progress", (pop_p.size() > 100), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
